// File: rtl/dsp_pkg.sv
// Shared DSP definitions for the chorus path (LFO and delay buffer).
package dsp_pkg;

    // Width of the folded triangle fed to the depth multiplier
    localparam int TRI_WIDTH = 16;

    // Buffer depth minus guard margin minus average delay (7680 - 10 - 882)
    localparam int DEFAULT_MAX_DEPTH = 6788;

    typedef enum logic [1:0] {
        LFO_IDLE,
        LFO_RUN,
        LFO_STOP
    } lfo_state_t;

endpackage

// File: rtl/lfo_depth_scaler.sv
// Second pipeline stage of the chorus LFO: folds the phase into a triangle,
// scales it by the active depth and registers the extra delay.
module lfo_depth_scaler
    import dsp_pkg::*;
#(
    parameter int ADDR_WIDTH = 13
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [TRI_WIDTH:0]      phase_hi_i,
    input  logic [ADDR_WIDTH-1:0]   depth_act_i,
    input  logic                    tick_d1_i,
    output logic [ADDR_WIDTH-1:0]   delay_o,
    output logic                    delay_valid_o
);

    localparam int PROD_WIDTH = TRI_WIDTH + ADDR_WIDTH;

    logic [TRI_WIDTH-1:0]  w_fold;
    logic [TRI_WIDTH-1:0]  w_tri;
    logic [PROD_WIDTH-1:0] w_prod;
    logic [ADDR_WIDTH-1:0] w_delay;

    // Falling half of the triangle mirrors the rising half, so the descending
    // side sits one LSB below the ascending side at matching offsets.
    assign w_fold  = phase_hi_i[TRI_WIDTH-1:0];
    assign w_tri   = phase_hi_i[TRI_WIDTH] ? ~w_fold : w_fold;
    assign w_prod  = {{ADDR_WIDTH{1'b0}}, w_tri} * {{TRI_WIDTH{1'b0}}, depth_act_i};
    assign w_delay = ADDR_WIDTH'(w_prod >> TRI_WIDTH);

    // Register the scaled delay once per delayed tick; hold it otherwise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            delay_o       <= '0;
            delay_valid_o <= 1'b0;
        end else begin
            delay_valid_o <= tick_d1_i;
            if (tick_d1_i) begin
                delay_o <= w_delay;
            end
        end
    end

endmodule

// File: rtl/chorus_lfo.sv
// Triangle LFO producing the chorus extra read delay. Phase accumulator,
// shadowed rate/depth (loaded only at the triangle zero point) and the
// run/stop sequencer live here; the fold and multiply live in the scaler.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// LFO_IDLE | phase parked at 0, delay computes to 0; enabled tick starts
// LFO_RUN  | phase advances every tick
// LFO_STOP | phase runs on until it wraps, then parks at 0
module chorus_lfo
    import dsp_pkg::*;
#(
    parameter int ADDR_WIDTH  = 13,
    parameter int PHASE_WIDTH = 24,
    parameter int RATE_WIDTH  = 16,
    parameter int MAX_DEPTH   = DEFAULT_MAX_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sample_tick_i,
    input  logic                    enable_i,
    input  logic [RATE_WIDTH-1:0]   rate_i,
    input  logic [ADDR_WIDTH-1:0]   depth_i,
    output logic [ADDR_WIDTH-1:0]   delay_o,
    output logic                    delay_valid_o
);

    localparam logic [ADDR_WIDTH-1:0] MAX_DEPTH_W = ADDR_WIDTH'(MAX_DEPTH);

    lfo_state_t              r_state;
    logic [PHASE_WIDTH-1:0]  r_phase;
    logic [RATE_WIDTH-1:0]   r_rate_act;
    logic [ADDR_WIDTH-1:0]   r_depth_act;
    logic                    r_at_zero;
    logic                    r_tick_d1;

    logic [RATE_WIDTH-1:0]   w_step;
    logic [PHASE_WIDTH:0]    w_sum;
    logic                    w_carry;
    logic [ADDR_WIDTH-1:0]   w_depth_clamp;

    // At the zero point the new rate takes effect on the very tick it loads
    assign w_step        = r_at_zero ? rate_i : r_rate_act;
    assign w_sum         = {1'b0, r_phase} + (PHASE_WIDTH+1)'(w_step);
    assign w_carry       = w_sum[PHASE_WIDTH];
    assign w_depth_clamp = (depth_i > MAX_DEPTH_W) ? MAX_DEPTH_W : depth_i;

    // Accumulator, shadow registers and sequencer, all advanced by the sample tick
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= LFO_IDLE;
            r_phase     <= '0;
            r_rate_act  <= '0;
            r_depth_act <= '0;
            r_at_zero   <= 1'b1;
            r_tick_d1   <= 1'b0;
        end else begin
            r_tick_d1 <= sample_tick_i;
            if (sample_tick_i) begin
                if (r_at_zero) begin
                    r_rate_act  <= rate_i;
                    r_depth_act <= w_depth_clamp;
                end
                case (r_state)
                    LFO_IDLE: begin
                        if (enable_i) begin
                            r_state   <= LFO_RUN;
                            r_phase   <= w_sum[PHASE_WIDTH-1:0];
                            r_at_zero <= w_carry;
                        end else begin
                            r_phase   <= '0;
                            r_at_zero <= 1'b1;
                        end
                    end
                    LFO_RUN: begin
                        r_phase   <= w_sum[PHASE_WIDTH-1:0];
                        r_at_zero <= w_carry;
                        if (!enable_i) begin
                            r_state <= LFO_STOP;
                        end
                    end
                    LFO_STOP: begin
                        if (w_carry) begin
                            r_state   <= LFO_IDLE;
                            r_phase   <= '0;
                            r_at_zero <= 1'b1;
                        end else if (enable_i) begin
                            r_state   <= LFO_RUN;
                            r_phase   <= w_sum[PHASE_WIDTH-1:0];
                            r_at_zero <= 1'b0;
                        end else if (r_rate_act == '0) begin
                            // A frozen phase would never wrap; accept the jump to 0
                            r_state   <= LFO_IDLE;
                            r_phase   <= '0;
                            r_at_zero <= 1'b1;
                        end else begin
                            r_phase   <= w_sum[PHASE_WIDTH-1:0];
                            r_at_zero <= 1'b0;
                        end
                    end
                    default: begin
                        r_state   <= LFO_IDLE;
                        r_phase   <= '0;
                        r_at_zero <= 1'b1;
                    end
                endcase
            end
        end
    end

    lfo_depth_scaler #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scaler (
        .clk           (clk),
        .rst_n         (rst_n),
        .phase_hi_i    (r_phase[PHASE_WIDTH-1 -: TRI_WIDTH+1]),
        .depth_act_i   (r_depth_act),
        .tick_d1_i     (r_tick_d1),
        .delay_o       (delay_o),
        .delay_valid_o (delay_valid_o)
    );

endmodule
